// File: rtl/ysyx_22041412_ifu.sv
// Instruction fetch unit: a three-state fetch engine with at most one outstanding memory request.
// Redirects from execute take effect immediately; any response already in flight is dropped.
module ysyx_22041412_ifu #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [63:0] mem_req_addr,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [63:0] out_pc
);

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic        drop_q, drop_d;
   logic [31:0] instr_q, instr_d;
   logic [63:0] outPc_q, outPc_d;

   logic [63:0] redirTarget;
   logic [63:0] pcPlus4;
   logic        unusedRedirLow;

   assign redirTarget    = {redirect_pc[63:2], 2'b00};
   assign pcPlus4        = pc_q + 64'd4;
   assign unusedRedirLow = ^redirect_pc[1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_REQ;
         pc_q    <= {RESET_PC[63:2], 2'b00};
         drop_q  <= 1'b0;
         instr_q <= NOP_INSTR;
         outPc_q <= 64'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         drop_q  <= drop_d;
         instr_q <= instr_d;
         outPc_q <= outPc_d;
      end
   end

   // Redirect outranks every other event; drop marks a response that belongs to a stale pc.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      drop_d  = drop_q;
      instr_d = instr_q;
      outPc_d = outPc_q;
      unique case (state_q)
         ST_REQ: begin
            if (redirect_valid) begin
               pc_d = redirTarget;
               if (mem_req_ready) begin
                  state_d = ST_WAIT;
                  drop_d  = 1'b1;
               end
            end else if (mem_req_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (redirect_valid) begin
               pc_d = redirTarget;
               if (mem_resp_valid) begin
                  state_d = ST_REQ;
                  drop_d  = 1'b0;
               end else begin
                  drop_d = 1'b1;
               end
            end else if (mem_resp_valid) begin
               if (drop_q) begin
                  state_d = ST_REQ;
                  drop_d  = 1'b0;
               end else begin
                  state_d = ST_HOLD;
                  instr_d = mem_resp_data;
                  outPc_d = pc_q;
               end
            end
         end
         ST_HOLD: begin
            if (redirect_valid) begin
               pc_d    = redirTarget;
               state_d = ST_REQ;
            end else if (out_ready) begin
               pc_d    = pcPlus4;
               state_d = ST_REQ;
            end
         end
         default: begin
            state_d = ST_REQ;
         end
      endcase
   end

   // The request is masked during reset so nothing is issued while rst is held.
   assign mem_req_valid = (state_q == ST_REQ) && !rst;
   assign mem_req_addr  = {pc_q[63:2], 2'b00};
   assign out_valid     = (state_q == ST_HOLD);
   assign out_instr     = instr_q;
   assign out_pc        = outPc_q;

endmodule

// File: tb/tb_ysyx_22041412_ifu.sv
// Scoreboard bench for the fetch unit: directed vectors push expected requests and
// instructions into queues, and monitors pop and compare as the DUT presents them.
module tb_ysyx_22041412_ifu;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } outExp_t;

   logic        clk;
   logic        rst;
   logic        memReqValid;
   logic        memReqReady;
   logic [63:0] memReqAddr;
   logic        memRespValid;
   logic [31:0] memRespData;
   logic        redirValid;
   logic [63:0] redirPc;
   logic        outValid;
   logic        outReady;
   logic [31:0] outInstr;
   logic [63:0] outPc;

   logic [63:0] expReqQ[$];
   outExp_t     expOutQ[$];
   int          checkCount = 0;
   int          passCount  = 0;
   logic        prevOutValid = 1'b0;

   ysyx_22041412_ifu #(.RESET_PC(64'h0000_0000_8000_0000)) dut (
      .clk           (clk),
      .rst           (rst),
      .mem_req_valid (memReqValid),
      .mem_req_ready (memReqReady),
      .mem_req_addr  (memReqAddr),
      .mem_resp_valid(memRespValid),
      .mem_resp_data (memRespData),
      .redirect_valid(redirValid),
      .redirect_pc   (redirPc),
      .out_valid     (outValid),
      .out_ready     (outReady),
      .out_instr     (outInstr),
      .out_pc        (outPc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Drive one cycle of inputs just after the rising edge, then wait to mid-cycle for checks.
   task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rd,
                                input logic redir, input logic [63:0] rpc, input logic ordy);
      @(posedge clk);
      #1;
      memReqReady  = rdy;
      memRespValid = rv;
      memRespData  = rd;
      redirValid   = redir;
      redirPc      = rpc;
      outReady     = ordy;
      @(negedge clk);
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
   endtask

   task automatic checkReq(input string name, input logic [63:0] addr);
      checkOutput({name, " req_valid"}, {63'd0, memReqValid}, 64'd1);
      checkOutput({name, " req_addr"}, memReqAddr, addr);
   endtask

   task automatic pulseReset();
      @(posedge clk);
      #1;
      rst          = 1'b1;
      memReqReady  = 1'b0;
      memRespValid = 1'b0;
      memRespData  = 32'd0;
      redirValid   = 1'b0;
      redirPc      = 64'd0;
      outReady     = 1'b0;
      @(negedge clk);
      checkOutput("rst req_valid", {63'd0, memReqValid}, 64'd0);
      checkOutput("rst out_valid", {63'd0, outValid}, 64'd0);
      checkOutput("rst out_instr", {32'd0, outInstr}, 64'h13);
      checkOutput("rst out_pc", outPc, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkReq("post-reset", 64'h8000_0000);
   endtask

   // Request monitor: every accepted request must match the next expected address.
   always @(negedge clk) begin
      if (!rst && memReqValid && memReqReady) begin
         checkCount++;
         if (expReqQ.size() == 0) begin
            $display("[TB] FAIL unexpected request: got addr %h expected none", memReqAddr);
         end else begin
            logic [63:0] e;
            e = expReqQ.pop_front();
            if (memReqAddr === e) passCount++;
            else $display("[TB] FAIL request addr: got %h expected %h", memReqAddr, e);
         end
      end
   end

   // Output monitor: each new presentation of out_valid must match the next expected instruction.
   always @(negedge clk) begin
      if (!rst && outValid && !prevOutValid) begin
         checkCount++;
         if (expOutQ.size() == 0) begin
            $display("[TB] FAIL unexpected out_valid: got pc %h instr %h expected none", outPc, outInstr);
         end else begin
            outExp_t e;
            e = expOutQ.pop_front();
            if (outPc === e.pc && outInstr === e.instr) passCount++;
            else $display("[TB] FAIL out: got pc %h instr %h expected pc %h instr %h", outPc, outInstr, e.pc, e.instr);
         end
      end
      prevOutValid <= outValid;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      memReqReady = 1'b0; memRespValid = 1'b0; memRespData = 32'd0;
      redirValid = 1'b0; redirPc = 64'd0; outReady = 1'b0;
      repeat (2) @(negedge clk);

      // Basic fetch with minimum latency and pc+4 after accept
      pulseReset();
      expReqQ.push_back(64'h8000_0000);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
      expOutQ.push_back('{pc: 64'h8000_0000, instr: 32'h0000_0413});
      applyStimulus(1'b0, 1'b1, 32'h0000_0413, 1'b0, 64'd0, 1'b0);
      checkOutput("wait req_valid", {63'd0, memReqValid}, 64'd0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
      checkOutput("hold out_valid", {63'd0, outValid}, 64'd1);
      idle();
      checkReq("after accept", 64'h8000_0004);

      // Backpressure on the request channel
      pulseReset();
      for (int i = 0; i < 5; i++) begin
         idle();
         checkReq("stall", 64'h8000_0000);
      end

      // Redirect during WAIT drops the in-flight response
      expReqQ.push_back(64'h8000_0000);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 64'h8000_1002, 1'b0);
      applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 64'd0, 1'b0);
      idle();
      checkOutput("drop out_valid", {63'd0, outValid}, 64'd0);
      checkReq("after drop", 64'h8000_1000);
      expReqQ.push_back(64'h8000_1000);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
      expOutQ.push_back('{pc: 64'h8000_1000, instr: 32'h0010_0093});
      applyStimulus(1'b0, 1'b1, 32'h0010_0093, 1'b0, 64'd0, 1'b0);

      // HOLD under backpressure, then redirect coinciding with out_ready
      for (int i = 0; i < 4; i++) begin
         idle();
         checkOutput("hold valid", {63'd0, outValid}, 64'd1);
         checkOutput("hold pc", outPc, 64'h8000_1000);
         checkOutput("hold instr", {32'd0, outInstr}, 64'h0010_0093);
         checkOutput("hold no req", {63'd0, memReqValid}, 64'd0);
      end
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 64'h8000_0100, 1'b1);
      idle();
      checkOutput("hold redir out_valid", {63'd0, outValid}, 64'd0);
      checkReq("hold redir", 64'h8000_0100);

      // Response outside WAIT is ignored
      applyStimulus(1'b0, 1'b1, 32'h1234_5678, 1'b0, 64'd0, 1'b0);
      idle();
      checkOutput("stray resp out_valid", {63'd0, outValid}, 64'd0);
      checkReq("stray resp", 64'h8000_0100);

      // Redirect in REQ without handshake, low bits forced to zero
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 64'h8000_0203, 1'b0);
      idle();
      checkReq("req redir", 64'h8000_0200);

      // Redirect coinciding with handshake
      expReqQ.push_back(64'h8000_0200);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 64'h8000_0300, 1'b0);
      applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 64'd0, 1'b0);
      idle();
      checkOutput("hs redir out_valid", {63'd0, outValid}, 64'd0);
      checkReq("hs redir", 64'h8000_0300);

      // Repeated redirects in WAIT: last target wins
      expReqQ.push_back(64'h8000_0300);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 64'h8000_0500, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 64'h8000_0600, 1'b0);
      applyStimulus(1'b0, 1'b1, 32'h0BAD_0BAD, 1'b0, 64'd0, 1'b0);
      idle();
      checkOutput("multi redir out_valid", {63'd0, outValid}, 64'd0);
      checkReq("multi redir", 64'h8000_0600);

      // Redirect in WAIT coinciding with the response
      expReqQ.push_back(64'h8000_0600);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
      applyStimulus(1'b0, 1'b1, 32'h0BAD_0BAD, 1'b1, 64'h8000_0400, 1'b0);
      idle();
      checkOutput("redir+resp out_valid", {63'd0, outValid}, 64'd0);
      checkReq("redir+resp", 64'h8000_0400);
      expReqQ.push_back(64'h8000_0400);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
      expOutQ.push_back('{pc: 64'h8000_0400, instr: 32'h0000_0513});
      applyStimulus(1'b0, 1'b1, 32'h0000_0513, 1'b0, 64'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
      idle();
      checkReq("drop cleared", 64'h8000_0404);

      // 64-bit pc wrap
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
      expReqQ.push_back(64'hFFFF_FFFF_FFFF_FFFC);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
      expOutQ.push_back('{pc: 64'hFFFF_FFFF_FFFF_FFFC, instr: 32'h0000_8067});
      applyStimulus(1'b0, 1'b1, 32'h0000_8067, 1'b0, 64'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
      idle();
      checkReq("wrap", 64'd0);

      // Reset while WAIT, late response after release is ignored
      expReqQ.push_back(64'd0);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
      pulseReset();
      applyStimulus(1'b0, 1'b1, 32'hCAFE_BABE, 1'b0, 64'd0, 1'b0);
      idle();
      checkOutput("late resp out_valid", {63'd0, outValid}, 64'd0);
      checkReq("late resp", 64'h8000_0000);
      expReqQ.push_back(64'h8000_0000);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
      expOutQ.push_back('{pc: 64'h8000_0000, instr: 32'h0000_0093});
      applyStimulus(1'b0, 1'b1, 32'h0000_0093, 1'b0, 64'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
      idle();
      checkReq("restart", 64'h8000_0004);

      repeat (3) idle();
      checkOutput("req queue drained", 64'(expReqQ.size()), 64'd0);
      checkOutput("out queue drained", 64'(expOutQ.size()), 64'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
